// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-order register-write scoreboard for an issue stage.
// Tracks up to DEPTH in-flight register-writing ops in a circular FIFO of
// destination indices and keeps a per-register pending-write (busy) vector.
// Issue is stalled on RAW/WAW hazards or when the FIFO is full; completions
// retire the oldest entry, kills squash the youngest entries.
// Optional build macro: HAZARD_SCOREBOARD_BYPASS_EN -- when defined, hazard
// and full are evaluated against post-completion state so an issue blocked
// only by the op completing this cycle goes through in the same cycle.
module hazard_scoreboard #(
  parameter int NREGS   = 32,
  parameter int DEPTH   = 4,
  parameter int R0_ZERO = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       iss_valid,
  output logic                       iss_ready,
  input  logic [$clog2(NREGS)-1:0]   iss_rd,
  input  logic [$clog2(NREGS)-1:0]   iss_rs1,
  input  logic [$clog2(NREGS)-1:0]   iss_rs2,
  input  logic                       iss_we,
  input  logic                       iss_use_rs1,
  input  logic                       iss_use_rs2,
  input  logic                       cmp_valid,
  input  logic [$clog2(NREGS)-1:0]   cmp_rd,
  input  logic                       kill_valid,
  input  logic [$clog2(DEPTH):0]     kill_cnt,
  output logic [NREGS-1:0]           busy,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       err
);

  localparam int RW = $clog2(NREGS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // FIFO storage and pointers; storage is not reset because only entries
  // between head and tail are ever read.
  logic [RW-1:0]    fifo_rd [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  // Next-state values
  logic [PW-1:0]    head_n;
  logic [PW-1:0]    tail_n;
  logic [CW-1:0]    count_n;
  logic [NREGS-1:0] busy_n;
  logic             err_n;
  logic [CW-1:0]    kill_n;
  logic             wr_en;

  // Issue qualification
  logic             tracked;
  logic             hazard;
  logic             iss_fire;
  logic [NREGS-1:0] busy_eff;
  logic             full_eff;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Register 0 is never tracked when R0_ZERO is set, so writes to it
  // neither occupy a FIFO slot nor set a busy bit.
  assign tracked = iss_we & !((R0_ZERO != 0) && (iss_rd == '0));

`ifdef HAZARD_SCOREBOARD_BYPASS_EN
  // Post-completion view: the head register being retired this cycle is
  // treated as no longer busy, and a retiring slot frees up a full FIFO.
  always_comb begin
    busy_eff = busy;
    if (cmp_valid && !empty) begin
      busy_eff[fifo_rd[head]] = 1'b0;
    end
  end

  assign full_eff = full & !(cmp_valid & !empty);
`else
  // Registered view only: no combinational path from cmp_* to iss_ready,
  // so an issue waits one cycle after the completion it depends on.
  always_comb begin
    busy_eff = busy;
  end

  assign full_eff = full;
`endif

  // RAW on either used source, plus WAW on the destination so that each
  // register has at most one pending write (this keeps busy bits exact).
  assign hazard = (iss_use_rs1 & busy_eff[iss_rs1])
                | (iss_use_rs2 & busy_eff[iss_rs2])
                | (iss_we      & busy_eff[iss_rd]);

  assign iss_ready = !kill_valid & !hazard & !(full_eff & tracked);
  assign iss_fire  = iss_valid & iss_ready;

  // Next-state evaluation in the fixed order completion, kill, issue.
  always_comb begin
    head_n  = head;
    tail_n  = tail;
    count_n = count;
    busy_n  = busy;
    err_n   = err;
    kill_n  = '0;
    wr_en   = 1'b0;

    if (cmp_valid) begin
      if (!empty) begin
        busy_n[fifo_rd[head]] = 1'b0;
        head_n  = head + 1'b1;
        count_n = count - 1'b1;
        if (cmp_rd != fifo_rd[head]) begin
          err_n = 1'b1;
        end
      end else begin
        err_n = 1'b1;
      end
    end

    if (kill_valid) begin
      if (kill_cnt > count_n) begin
        kill_n = count_n;
        err_n  = 1'b1;
      end else begin
        kill_n = kill_cnt;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (i < int'(kill_n)) begin
          busy_n[fifo_rd[tail - PW'(i + 1)]] = 1'b0;
        end
      end
      tail_n  = tail - PW'(kill_n);
      count_n = count_n - kill_n;
    end

    if (iss_fire && tracked) begin
      wr_en          = 1'b1;
      busy_n[iss_rd] = 1'b1;
      tail_n         = tail_n + 1'b1;
      count_n        = count_n + 1'b1;
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      err   <= 1'b0;
    end else begin
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
      busy  <= busy_n;
      err   <= err_n;
    end
  end

  // Enqueue the destination index; issue never coincides with a kill, so
  // the current tail is the write slot.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_rd[tail] <= iss_rd;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed self-checking bench for hazard_scoreboard
// with default parameters (NREGS=32, DEPTH=4, R0_ZERO=1).
module tb_hazard_scoreboard;

`ifdef HAZARD_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        iss_valid;
  logic        iss_ready;
  logic [4:0]  iss_rd;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic        iss_we;
  logic        iss_use_rs1;
  logic        iss_use_rs2;
  logic        cmp_valid;
  logic [4:0]  cmp_rd;
  logic        kill_valid;
  logic [2:0]  kill_cnt;
  logic [31:0] busy;
  logic [2:0]  count;
  logic        empty;
  logic        full;
  logic        err;

  int n_checks;
  int n_pass;

  hazard_scoreboard #(.NREGS(32), .DEPTH(4), .R0_ZERO(1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .iss_valid   (iss_valid),
    .iss_ready   (iss_ready),
    .iss_rd      (iss_rd),
    .iss_rs1     (iss_rs1),
    .iss_rs2     (iss_rs2),
    .iss_we      (iss_we),
    .iss_use_rs1 (iss_use_rs1),
    .iss_use_rs2 (iss_use_rs2),
    .cmp_valid   (cmp_valid),
    .cmp_rd      (cmp_rd),
    .kill_valid  (kill_valid),
    .kill_cnt    (kill_cnt),
    .busy        (busy),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    iss_valid   = 1'b0;
    iss_rd      = '0;
    iss_rs1     = '0;
    iss_rs2     = '0;
    iss_we      = 1'b0;
    iss_use_rs1 = 1'b0;
    iss_use_rs2 = 1'b0;
    cmp_valid   = 1'b0;
    cmp_rd      = '0;
    kill_valid  = 1'b0;
    kill_cnt    = '0;
  endtask

  task automatic set_issue(input logic [4:0] rd, input logic [4:0] rs1,
                           input logic we, input logic use1);
    iss_valid   = 1'b1;
    iss_rd      = rd;
    iss_rs1     = rs1;
    iss_rs2     = '0;
    iss_we      = we;
    iss_use_rs1 = use1;
    iss_use_rs2 = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    #3;
    n_checks++; if (count !== 3'd0) $display("[TB] FAIL reset_count: got %0d expected 0", count); else n_pass++;
    n_checks++; if (busy !== 32'h0) $display("[TB] FAIL reset_busy: got %h expected 0", busy); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err); else n_pass++;
    n_checks++; if (empty !== 1'b1 || full !== 1'b0) $display("[TB] FAIL reset_flags: empty=%b full=%b expected 1/0", empty, full); else n_pass++;
    n_checks++; if (iss_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", iss_ready); else n_pass++;
    do_reset();
  endtask

  task automatic test_raw();
    do_reset();
    set_issue(5'd5, 5'd0, 1'b1, 1'b0);
    #1;
    n_checks++; if (iss_ready !== 1'b1) $display("[TB] FAIL raw_first_ready: got %b expected 1", iss_ready); else n_pass++;
    tick();
    set_issue(5'd9, 5'd5, 1'b0, 1'b1);
    #1;
    n_checks++; if (iss_ready !== 1'b0) $display("[TB] FAIL raw_stall: got %b expected 0", iss_ready); else n_pass++;
    n_checks++; if (busy !== 32'h20) $display("[TB] FAIL raw_busy5: got %h expected 00000020", busy); else n_pass++;
    n_checks++; if (count !== 3'd1) $display("[TB] FAIL raw_count: got %0d expected 1", count); else n_pass++;
    cmp_valid = 1'b1;
    cmp_rd    = 5'd5;
    #1;
    n_checks++; if (iss_ready !== BYP) $display("[TB] FAIL raw_bypass_ready: got %b expected %b", iss_ready, BYP); else n_pass++;
    tick();
    cmp_valid = 1'b0;
    #1;
    n_checks++; if (busy !== 32'h0) $display("[TB] FAIL raw_busy_clear: got %h expected 0", busy); else n_pass++;
    n_checks++; if (iss_ready !== 1'b1) $display("[TB] FAIL raw_ready_after: got %b expected 1", iss_ready); else n_pass++;
    tick();
    clear_inputs();
    n_checks++; if (count !== 3'd0 || err !== 1'b0) $display("[TB] FAIL raw_end: count=%0d err=%b expected 0/0", count, err); else n_pass++;
  endtask

  task automatic test_full();
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      set_issue(5'(r), 5'd0, 1'b1, 1'b0);
      tick();
    end
    set_issue(5'd6, 5'd0, 1'b1, 1'b0);
    #1;
    n_checks++; if (full !== 1'b1 || count !== 3'd4) $display("[TB] FAIL full_flag: full=%b count=%0d expected 1/4", full, count); else n_pass++;
    n_checks++; if (busy !== 32'h1E) $display("[TB] FAIL full_busy: got %h expected 0000001e", busy); else n_pass++;
    n_checks++; if (iss_ready !== 1'b0) $display("[TB] FAIL full_stall: got %b expected 0", iss_ready); else n_pass++;
    cmp_valid = 1'b1;
    cmp_rd    = 5'd1;
    #1;
    n_checks++; if (iss_ready !== BYP) $display("[TB] FAIL full_bypass_ready: got %b expected %b", iss_ready, BYP); else n_pass++;
    tick();
    cmp_valid = 1'b0;
    n_checks++; if (count !== (BYP ? 3'd4 : 3'd3)) $display("[TB] FAIL full_count_after_cmp: got %0d expected %0d", count, BYP ? 4 : 3); else n_pass++;
    n_checks++; if (busy[6] !== BYP || busy[1] !== 1'b0) $display("[TB] FAIL full_busy_after_cmp: busy6=%b busy1=%b expected %b/0", busy[6], busy[1], BYP); else n_pass++;
    #1;
    n_checks++; if (iss_ready !== !BYP) $display("[TB] FAIL full_ready_next: got %b expected %b", iss_ready, !BYP); else n_pass++;
    tick();
    clear_inputs();
    n_checks++; if (count !== 3'd4 || busy !== 32'h5C) $display("[TB] FAIL full_final: count=%0d busy=%h expected 4/0000005c", count, busy); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("[TB] FAIL full_err: got %b expected 0", err); else n_pass++;
  endtask

  task automatic test_kill();
    do_reset();
    for (int r = 1; r <= 3; r++) begin
      set_issue(5'(r), 5'd0, 1'b1, 1'b0);
      tick();
    end
    clear_inputs();
    set_issue(5'd9, 5'd0, 1'b1, 1'b0);
    kill_valid = 1'b1;
    kill_cnt   = 3'd2;
    #1;
    n_checks++; if (iss_ready !== 1'b0) $display("[TB] FAIL kill_blocks_issue: got %b expected 0", iss_ready); else n_pass++;
    tick();
    n_checks++; if (count !== 3'd1 || busy !== 32'h2) $display("[TB] FAIL kill_two: count=%0d busy=%h expected 1/00000002", count, busy); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("[TB] FAIL kill_two_err: got %b expected 0", err); else n_pass++;
    iss_valid = 1'b0;
    kill_cnt  = 3'd5;
    tick();
    clear_inputs();
    n_checks++; if (count !== 3'd0 || busy !== 32'h0) $display("[TB] FAIL kill_over: count=%0d busy=%h expected 0/0", count, busy); else n_pass++;
    n_checks++; if (err !== 1'b1) $display("[TB] FAIL kill_over_err: got %b expected 1", err); else n_pass++;
  endtask

  task automatic test_r0();
    do_reset();
    set_issue(5'd0, 5'd0, 1'b1, 1'b0);
    #1;
    n_checks++; if (iss_ready !== 1'b1) $display("[TB] FAIL r0_ready: got %b expected 1", iss_ready); else n_pass++;
    tick();
    clear_inputs();
    n_checks++; if (count !== 3'd0 || busy !== 32'h0) $display("[TB] FAIL r0_untracked: count=%0d busy=%h expected 0/0", count, busy); else n_pass++;
    cmp_valid = 1'b1;
    cmp_rd    = 5'd0;
    tick();
    clear_inputs();
    n_checks++; if (err !== 1'b1 || count !== 3'd0) $display("[TB] FAIL r0_empty_cmp: err=%b count=%0d expected 1/0", err, count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_busy;
    logic [2:0]  exp_cnt;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      clear_inputs();
      if (k < 8) set_issue(5'(10 + k), 5'd0, 1'b1, 1'b0);
      if (k > 0) begin
        cmp_valid = 1'b1;
        cmp_rd    = 5'(9 + k);
      end
      #1;
      n_checks++; if (iss_ready !== 1'b1) $display("[TB] FAIL b2b_ready_%0d: got %b expected 1", k, iss_ready); else n_pass++;
      tick();
      exp_busy = (k < 8) ? (32'd1 << (10 + k)) : 32'd0;
      exp_cnt  = (k < 8) ? 3'd1 : 3'd0;
      n_checks++; if (busy !== exp_busy || count !== exp_cnt) $display("[TB] FAIL b2b_state_%0d: busy=%h count=%0d expected %h/%0d", k, busy, count, exp_busy, exp_cnt); else n_pass++;
    end
    clear_inputs();
    n_checks++; if (err !== 1'b0) $display("[TB] FAIL b2b_err: got %b expected 0", err); else n_pass++;
    set_issue(5'd7, 5'd0, 1'b1, 1'b0);
    tick();
    set_issue(5'd8, 5'd0, 1'b1, 1'b0);
    tick();
    clear_inputs();
    cmp_valid = 1'b1;
    cmp_rd    = 5'd9;
    tick();
    n_checks++; if (err !== 1'b1) $display("[TB] FAIL mismatch_err: got %b expected 1", err); else n_pass++;
    n_checks++; if (count !== 3'd1 || busy !== 32'h100) $display("[TB] FAIL mismatch_dequeue: count=%0d busy=%h expected 1/00000100", count, busy); else n_pass++;
    cmp_rd = 5'd8;
    tick();
    clear_inputs();
    n_checks++; if (count !== 3'd0 || busy !== 32'h0) $display("[TB] FAIL mismatch_drain: count=%0d busy=%h expected 0/0", count, busy); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      set_issue(5'(r), 5'd0, 1'b1, 1'b0);
      tick();
    end
    clear_inputs();
    cmp_valid = 1'b1;
    cmp_rd    = 5'd9;
    tick();
    clear_inputs();
    n_checks++; if (count !== 3'd3 || err !== 1'b1) $display("[TB] FAIL areset_pre: count=%0d err=%b expected 3/1", count, err); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0 || busy !== 32'h0 || err !== 1'b0) $display("[TB] FAIL areset_clear: count=%0d busy=%h err=%b expected 0/0/0", count, busy, err); else n_pass++;
    @(posedge clk);
    #6 reset_n = 1'b1;
    set_issue(5'd1, 5'd2, 1'b1, 1'b1);
    #1;
    n_checks++; if (iss_ready !== 1'b1) $display("[TB] FAIL areset_ready: got %b expected 1", iss_ready); else n_pass++;
    tick();
    clear_inputs();
    n_checks++; if (count !== 3'd1 || busy !== 32'h2) $display("[TB] FAIL areset_reissue: count=%0d busy=%h expected 1/00000002", count, busy); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clear_inputs();
    reset_n = 1'b0;
    test_reset();
    test_raw();
    test_full();
    test_kill();
    test_r0();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
